// File: rtl/daq_uart_streamer.sv
// daq_uart_streamer: buffers 12-bit ADC samples in an 8-deep FIFO and streams
// each sample over an 8N1 UART line as two bytes:
//   byte 0 = {HDR_NIBBLE, sample[11:8]}, byte 1 = sample[7:0].
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   din[11:0], din_valid    sample input and its one-cycle strobe
//   clr_overflow            synchronous clear of the sticky overflow flag
//   uart_tx                 registered serial output, idle high
//   busy                    transmitter not idle
//   fifo_count[3:0]         samples currently buffered (0..8)
//   fifo_full, overflow     FIFO full / sample-dropped sticky flag
module daq_uart_streamer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [3:0]  HDR_NIBBLE   = 4'hA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] din,
  input  logic        din_valid,
  input  logic        clr_overflow,
  output logic        uart_tx,
  output logic        busy,
  output logic [3:0]  fifo_count,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned BW    = 16;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] hold;
  logic          byte_idx;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;

  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic          baud_done_c;
  logic [CW-1:0] count_nxt_c;
  logic [7:0]    cur_byte_c;

  // FIFO handshake, next occupancy and the byte currently on the wire
  always_comb begin
    pop_c       = (state == IDLE) && (fifo_count != '0);
    // A full FIFO still accepts a write on the edge that pops the head
    push_c      = din_valid && ((fifo_count != CW'(DEPTH)) || pop_c);
    drop_c      = din_valid && !push_c;
    count_nxt_c = fifo_count;
    if (push_c && !pop_c) begin
      count_nxt_c = fifo_count + CW'(1);
    end else if (pop_c && !push_c) begin
      count_nxt_c = fifo_count - CW'(1);
    end
    baud_done_c = (baud_cnt == BAUD_LAST);
    cur_byte_c  = byte_idx ? hold[7:0] : {HDR_NIBBLE, hold[11:8]};
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= count_nxt_c;
      fifo_full  <= (count_nxt_c == CW'(DEPTH));
      // A drop on the clearing edge wins so that no loss goes unreported
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Transmit FSM: two back-to-back 8N1 bytes per popped sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      hold     <= '0;
      byte_idx <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          if (pop_c) begin
            hold     <= mem[rd_ptr];
            byte_idx <= 1'b0;
            bit_cnt  <= '0;
            uart_tx  <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= cur_byte_c[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              uart_tx <= cur_byte_c[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            if (!byte_idx) begin
              // Second byte follows immediately, no idle gap
              byte_idx <= 1'b1;
              uart_tx  <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_uart_streamer.sv
// Bench for daq_uart_streamer: a queue/countdown reference model plus UART
// receiver monitors that decode the serial line back into bytes.
module tb_daq_uart_streamer;

  localparam int unsigned C  = 4;
  localparam int unsigned C2 = 868;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        uart_tx, busy, fifo_full, overflow;
  logic [3:0]  fifo_count;

  logic [11:0] din2 = '0;
  logic        din_valid2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        uart_tx2, busy2, fifo_full2, overflow2;
  logic [3:0]  fifo_count2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [11:0] m_q[$];
  logic [11:0] m_sent[$];
  int          m_busy_left = 0;
  bit          m_ovf = 1'b0;

  // Decoded {stop_bit, data} from the serial lines
  logic [8:0]  rx_q[$];
  logic [8:0]  rx2_q[$];

  logic [6:0]  d_stat;
  assign d_stat = {busy, fifo_count, fifo_full, overflow};

  daq_uart_streamer #(.CLKS_PER_BIT(C), .HDR_NIBBLE(4'hA)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .clr_overflow(clr_overflow), .uart_tx(uart_tx), .busy(busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
  );

  daq_uart_streamer dut868 (
    .clk(clk), .reset_n(reset_n), .din(din2), .din_valid(din_valid2),
    .clr_overflow(clr2), .uart_tx(uart_tx2), .busy(busy2),
    .fifo_count(fifo_count2), .fifo_full(fifo_full2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] m_stat();
    return {(m_busy_left != 0), 4'(m_q.size()), (m_q.size() == 8), m_ovf};
  endfunction

  function automatic logic [8:0] exp_byte(input logic [11:0] s, input bit idx);
    return idx ? {1'b1, s[7:0]} : {1'b1, 4'hA, s[11:8]};
  endfunction

  // Model: a sample queue and a transmitter that is busy 20 bit times per pop
  initial begin
    int sz;
    bit pop;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_q.delete();
        m_busy_left = 0;
        m_ovf = 1'b0;
      end else begin
        sz  = m_q.size();
        pop = (m_busy_left == 0) && (sz > 0);
        if (pop) begin
          m_sent.push_back(m_q.pop_front());
          m_busy_left = 20 * C;
        end else if (m_busy_left > 0) begin
          m_busy_left--;
        end
        if (din_valid && (sz < 8 || pop)) m_q.push_back(din);
        if (din_valid && sz == 8 && !pop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
      end
    end
  end

  // UART receiver: detect falling edge, sample mid-bit
  task automatic mon(input bit sel, input int c);
    logic prev, b;
    logic [7:0] d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      b = sel ? uart_tx2 : uart_tx;
      if (prev && !b) begin
        repeat (c / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (c) @(negedge clk);
          d[i] = sel ? uart_tx2 : uart_tx;
        end
        repeat (c) @(negedge clk);
        b = sel ? uart_tx2 : uart_tx;
        if (sel) rx2_q.push_back({b, d});
        else     rx_q.push_back({b, d});
      end
      prev = b;
    end
  endtask

  initial mon(1'b0, C);
  initial mon(1'b1, C2);

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    total++; if (uart_tx2 !== 1'b1) begin bad++; $display("FAIL reset_tx2: got %b want 1", uart_tx2); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [11:0] vals[4];
    logic [8:0]  b;
    int n;
    vals[0] = 12'h789;
    for (int i = 1; i < 4; i++) vals[i] = 12'($urandom);
    for (int i = 0; i < 4; i++) begin
      // First sample lands on the very first edge after reset release
      if (i > 0) @(negedge clk);
      din = vals[i]; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      total++;
      if (uart_tx !== 1'b1 || fifo_count !== 4'd1) begin
        bad++; $display("FAIL single_prestart: tx=%b count=%0d want tx=1 count=1", uart_tx, fifo_count);
      end
      @(negedge clk);
      total++;
      if (uart_tx !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL single_latency: tx=%b busy=%b want tx=0 busy=1", uart_tx, busy);
      end
      n = 1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        total++;
        if (d_stat !== m_stat()) begin bad++; $display("FAIL single_status: got %b want %b", d_stat, m_stat()); end
        if (!busy) break;
        n++;
      end
      total++; if (n != 20 * C) begin bad++; $display("FAIL single_frame_len: got %0d want %0d", n, 20 * C); end
      repeat (3) @(negedge clk);
      total++;
      if (rx_q.size() != 2) begin
        bad++; $display("FAIL single_rx_count: got %0d want 2", rx_q.size());
      end else begin
        for (int j = 0; j < 2; j++) begin
          b = rx_q.pop_front();
          total++;
          if (b !== exp_byte(vals[i], j[0])) begin
            bad++; $display("FAIL single_byte%0d: got %h want %h", j, b, exp_byte(vals[i], j[0]));
          end
        end
      end
      rx_q.delete(); m_sent.delete();
    end
  endtask

  task automatic test_burst();
    int peak, k;
    logic [8:0] b;
    peak = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      total++; if (d_stat !== m_stat()) begin bad++; $display("FAIL burst_status: got %b want %b", d_stat, m_stat()); end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      din = 12'(i); din_valid = 1'b1;
      clr_overflow = (i == 10);  // clear collides with the dropped sample
    end
    @(negedge clk);
    din_valid = 1'b0; clr_overflow = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL burst_ovf_set: got %b want 1", overflow); end
    for (k = 0; k < 1500; k++) begin
      @(negedge clk);
      total++; if (d_stat !== m_stat()) begin bad++; $display("FAIL burst_status: got %b want %b", d_stat, m_stat()); end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!busy && fifo_count == 4'd0 && m_q.size() == 0 && m_busy_left == 0) break;
    end
    total++; if (k == 1500) begin bad++; $display("FAIL burst_drain_timeout: count=%0d busy=%b", fifo_count, busy); end
    total++; if (peak != 8) begin bad++; $display("FAIL burst_peak: got %0d want 8", peak); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL burst_ovf_hold: got %b want 1", overflow); end
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_ovf_clr: got %b want 0", overflow); end
    repeat (3) @(negedge clk);
    total++;
    if (rx_q.size() != 18) begin
      bad++; $display("FAIL burst_rx_count: got %0d want 18", rx_q.size());
    end else begin
      for (int i = 1; i <= 9; i++) begin
        for (int j = 0; j < 2; j++) begin
          b = rx_q.pop_front();
          total++;
          if (b !== exp_byte(12'(i), j[0])) begin
            bad++; $display("FAIL burst_byte s%0d b%0d: got %h want %h", i, j, b, exp_byte(12'(i), j[0]));
          end
        end
      end
    end
    rx_q.delete(); m_sent.delete();
  endtask

  task automatic test_wrap();
    logic [11:0] vals[20];
    logic [8:0]  b;
    int sent, k;
    for (int i = 0; i < 20; i++) vals[i] = 12'($urandom);
    sent = 0;
    for (k = 0; k < 6000; k++) begin
      @(negedge clk);
      total++; if (d_stat !== m_stat()) begin bad++; $display("FAIL wrap_status: got %b want %b", d_stat, m_stat()); end
      din_valid = 1'b0;
      if (sent < 20) begin
        if (m_q.size() < 3 && (m_q.size() == 0 || $urandom_range(0, 3) == 0)) begin
          din = vals[sent]; din_valid = 1'b1; sent++;
        end
      end else if (!busy && m_q.size() == 0 && m_busy_left == 0) begin
        break;
      end
    end
    din_valid = 1'b0;
    total++; if (k == 6000) begin bad++; $display("FAIL wrap_timeout: sent=%0d", sent); end
    repeat (3) @(negedge clk);
    total++;
    if (rx_q.size() != 40) begin
      bad++; $display("FAIL wrap_rx_count: got %0d want 40", rx_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        for (int j = 0; j < 2; j++) begin
          b = rx_q.pop_front();
          total++;
          if (b !== exp_byte(vals[i], j[0])) begin
            bad++; $display("FAIL wrap_byte s%0d b%0d: got %h want %h", i, j, b, exp_byte(vals[i], j[0]));
          end
        end
      end
    end
    rx_q.delete(); m_sent.delete();
  endtask

  task automatic test_simultaneous();
    logic [11:0] vals[10];
    logic [8:0]  b;
    int k;
    for (int i = 0; i < 10; i++) vals[i] = 12'($urandom);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      din = vals[i]; din_valid = 1'b1;
    end
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      total++; if (d_stat !== m_stat()) begin bad++; $display("FAIL simul_status: got %b want %b", d_stat, m_stat()); end
      if (!busy && fifo_count == 4'd8) break;
    end
    total++; if (k == 300) begin bad++; $display("FAIL simul_wait_timeout: count=%0d busy=%b", fifo_count, busy); end
    // Write lands on the edge that pops the head of a full FIFO
    din = vals[9]; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL simul_count: got %0d want 8", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL simul_ovf: got %b want 0", overflow); end
    total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL simul_full: got %b want 1", fifo_full); end
    for (k = 0; k < 1500; k++) begin
      @(negedge clk);
      total++; if (d_stat !== m_stat()) begin bad++; $display("FAIL simul_status: got %b want %b", d_stat, m_stat()); end
      if (!busy && m_q.size() == 0 && m_busy_left == 0) break;
    end
    total++; if (k == 1500) begin bad++; $display("FAIL simul_drain_timeout: count=%0d", fifo_count); end
    repeat (3) @(negedge clk);
    total++;
    if (rx_q.size() != 20) begin
      bad++; $display("FAIL simul_rx_count: got %0d want 20", rx_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < 2; j++) begin
          b = rx_q.pop_front();
          total++;
          if (b !== exp_byte(vals[i], j[0])) begin
            bad++; $display("FAIL simul_byte s%0d b%0d: got %h want %h", i, j, b, exp_byte(vals[i], j[0]));
          end
        end
      end
    end
    rx_q.delete(); m_sent.delete();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din = 12'($urandom); din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    // Pop was ~4 cycles ago; byte 1 data bits span 44..76 cycles after it
    repeat (52) @(negedge clk);
    total++;
    if (busy !== 1'b1 || fifo_count !== 4'd3) begin
      bad++; $display("FAIL rstmid_pre: busy=%b count=%0d want busy=1 count=3", busy, fifo_count);
    end
    #2 reset_n = 1'b0;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", uart_tx); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete(); m_sent.delete();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      total++;
      if (uart_tx !== 1'b1 || d_stat !== m_stat()) begin
        bad++; $display("FAIL rstmid_quiet: tx=%b stat=%b want tx=1 stat=%b", uart_tx, d_stat, m_stat());
      end
    end
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rstmid_rx: got %0d frames want 0", rx_q.size()); end
  endtask

  task automatic test_baud_868();
    logic [8:0] b;
    int n, k;
    @(negedge clk);
    din2 = 12'h789; din_valid2 = 1'b1;
    @(negedge clk);
    din_valid2 = 1'b0;
    total++; if (uart_tx2 !== 1'b1) begin bad++; $display("FAIL b868_prestart: got %b want 1", uart_tx2); end
    @(negedge clk);
    total++; if (uart_tx2 !== 1'b0) begin bad++; $display("FAIL b868_latency: got %b want 0", uart_tx2); end
    n = 1;
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (!busy2) break;
      n++;
    end
    total++; if (n != 20 * C2) begin bad++; $display("FAIL b868_frame_len: got %0d want %0d", n, 20 * C2); end
    repeat (3) @(negedge clk);
    total++;
    if (rx2_q.size() != 2) begin
      bad++; $display("FAIL b868_rx_count: got %0d want 2", rx2_q.size());
    end else begin
      b = rx2_q.pop_front();
      total++; if (b !== 9'h1A7) begin bad++; $display("FAIL b868_byte0: got %h want 1a7", b); end
      b = rx2_q.pop_front();
      total++; if (b !== 9'h189) begin bad++; $display("FAIL b868_byte1: got %h want 189", b); end
    end
    total++; if (fifo_count2 !== 4'd0) begin bad++; $display("FAIL b868_count: got %0d want 0", fifo_count2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_baud_868();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
